// File: rtl/multip_pkg.sv
// Shared types and helpers for the sequential shift-add multiplier.
package multip_pkg;

    localparam int MULTIP_NB_BITS_DEF = 8;
    localparam int MULTIP_MAX_BITS    = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

    // The caller zero-extends its operand and keeps the low N bits of the result.
    // The most negative N-bit value maps to 2^(N-1), which still fits unsigned in N bits.
    function automatic logic [MULTIP_MAX_BITS-1:0] mag(
        input logic [MULTIP_MAX_BITS-1:0] val,
        input logic                       neg
    );
        return neg ? (~val + MULTIP_MAX_BITS'(1)) : val;
    endfunction

endpackage

// File: rtl/adder_nbits.sv
// Combinational accumulate adder for the shift-add multiplier; the carry-out is dropped.
module adder_nbits
    import multip_pkg::*;
#(
    parameter int NB_BITS = 2 * MULTIP_NB_BITS_DEF
)
(
    input  logic [NB_BITS-1:0] a,
    input  logic [NB_BITS-1:0] b,
    output logic [NB_BITS-1:0] sum
);

    assign sum = a + b;

endmodule

// File: rtl/multip_seq_nbits.sv
// Sequential shift-add multiplier, one partial product per clock, signed or unsigned.
// Optional early termination when the remaining multiplier is zero: MULTIP_SEQ_EARLY_TERM_EN.
module multip_seq_nbits
    import multip_pkg::*;
#(
    parameter int NB_BITS = MULTIP_NB_BITS_DEF
)
(
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic                   start_i,
    input  logic                   signed_i,
    input  logic [NB_BITS-1:0]     op1_i,
    input  logic [NB_BITS-1:0]     op2_i,
    output logic                   busy_o,
    output logic                   valid_o,
    output logic [2*NB_BITS-1:0]   s_o
);

    localparam int PW    = 2 * NB_BITS;
    localparam int CNT_W = $clog2(NB_BITS);

    state_t             state;
    state_t             state_nxt;
    logic [PW-1:0]      mcand;
    logic [PW-1:0]      acc;
    logic [PW-1:0]      acc_sum;
    logic [PW-1:0]      acc_nxt;
    logic [NB_BITS-1:0] mplr;
    logic [CNT_W-1:0]   cnt;
    logic               neg;
    logic               last_step;

    adder_nbits #(.NB_BITS(PW)) u_adder (
        .a   (acc),
        .b   (mcand),
        .sum (acc_sum)
    );

    assign acc_nxt = mplr[0] ? acc_sum : acc;

`ifdef MULTIP_SEQ_EARLY_TERM_EN
    assign last_step = (cnt == CNT_W'(NB_BITS - 1)) || (mplr[NB_BITS-1:1] == '0);
`else
    assign last_step = (cnt == CNT_W'(NB_BITS - 1));
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy_o    = 1'b0;
        valid_o   = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                busy_o = 1'b1;
                if (last_step) begin
                    state_nxt = FIN;
                end
            end
            FIN: begin
                busy_o    = 1'b1;
                valid_o   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: operands are loaded as magnitudes, the sign is reapplied on the last step
    // so that s_o is already stable during the FIN cycle in which valid_o is high.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            mcand <= '0;
            mplr  <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            s_o   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        mcand <= PW'(NB_BITS'(mag(MULTIP_MAX_BITS'(op1_i),
                                                  signed_i & op1_i[NB_BITS-1])));
                        mplr  <= NB_BITS'(mag(MULTIP_MAX_BITS'(op2_i),
                                              signed_i & op2_i[NB_BITS-1]));
                        neg   <= signed_i & (op1_i[NB_BITS-1] ^ op2_i[NB_BITS-1]);
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                RUN: begin
                    acc   <= acc_nxt;
                    mcand <= mcand << 1;
                    mplr  <= mplr >> 1;
                    cnt   <= cnt + CNT_W'(1);
                    if (last_step) begin
                        s_o <= neg ? (~acc_nxt + PW'(1)) : acc_nxt;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multip_seq_nbits.sv
// Directed bench for multip_seq_nbits: an 8-bit instance for hand vectors and a 4-bit one swept exhaustively.
module tb_multip_seq_nbits;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start8, signed8, busy8, valid8;
    logic [7:0]  a8, b8;
    logic [15:0] s8;

    logic        start4, signed4, busy4, valid4;
    logic [3:0]  a4, b4;
    logic [7:0]  s4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multip_seq_nbits #(.NB_BITS(8)) dut8 (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .start_i  (start8),
        .signed_i (signed8),
        .op1_i    (a8),
        .op2_i    (b8),
        .busy_o   (busy8),
        .valid_o  (valid8),
        .s_o      (s8)
    );

    multip_seq_nbits #(.NB_BITS(4)) dut4 (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .start_i  (start4),
        .signed_i (signed4),
        .op1_i    (a4),
        .op2_i    (b4),
        .busy_o   (busy4),
        .valid_o  (valid4),
        .s_o      (s4)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Cycles from the accept cycle to the valid_o cycle.
    function automatic int exp_lat(input int n, input logic sgn, input logic [31:0] b);
        longint mb;
        int     hsb;
        mb = longint'(b);
        if (sgn && b[n-1]) mb = (longint'(1) << n) - longint'(b);
        hsb = 0;
        for (int i = 0; i < n; i++) if (mb[i]) hsb = i;
`ifdef MULTIP_SEQ_EARLY_TERM_EN
        return 2 + hsb;
`else
        return (hsb >= 0) ? n + 1 : 0;
`endif
    endfunction

    task automatic op8(input logic sgn, input logic [7:0] a, input logic [7:0] b,
                       input logic [15:0] exp, input string tag);
        int lat;
        int busy_cnt;
        int elat;
        elat = exp_lat(8, sgn, 32'(b));
        signed8 = sgn; a8 = a; b8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        start8   = 1'b0;
        lat      = 1;
        busy_cnt = 0;
        while (!valid8 && lat < 40) begin
            if (busy8) busy_cnt++;
            @(posedge clk); #1;
            lat++;
        end
        if (busy8) busy_cnt++;
        check({tag, " valid"},   32'(valid8),   32'd1);
        check({tag, " latency"}, 32'(lat),      32'(elat));
        check({tag, " busy"},    32'(busy_cnt), 32'(elat));
        check({tag, " product"}, 32'(s8),       32'(exp));
        @(posedge clk); #1;
        check({tag, " pulse"},   32'(valid8),   32'd0);
        check({tag, " held"},    32'(s8),       32'(exp));
    endtask

    task automatic op4(input logic sgn, input logic [3:0] a, input logic [3:0] b,
                       input logic [7:0] exp);
        int lat;
        signed4 = sgn; a4 = a; b4 = b; start4 = 1'b1;
        @(posedge clk); #1;
        start4 = 1'b0;
        lat    = 1;
        while (!valid4 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check($sformatf("n4 s%0d %0d*%0d valid", sgn, a, b), 32'(valid4), 32'd1);
        check($sformatf("n4 s%0d %0d*%0d lat", sgn, a, b), 32'(lat), 32'(exp_lat(4, sgn, 32'(b))));
        check($sformatf("n4 s%0d %0d*%0d prod", sgn, a, b), 32'(s4), 32'(exp));
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int nvalid;
        logic [15:0] got;
        int sa, sb;

        rst_n = 1'b0;
        start8 = 1'b0; signed8 = 1'b0; a8 = '0; b8 = '0;
        start4 = 1'b0; signed4 = 1'b0; a4 = '0; b4 = '0;

        @(posedge clk); #1;
        check("reset busy",  32'(busy8),  32'd0);
        check("reset valid", 32'(valid8), 32'd0);
        check("reset s",     32'(s8),     32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        op8(1'b0, 8'd255, 8'd255, 16'hFE01, "u255x255");
        op8(1'b1, 8'h80,  8'h80,  16'h4000, "s-128x-128");
        op8(1'b1, 8'hFF,  8'h7F,  16'hFF81, "s-1x127");
        op8(1'b1, 8'd5,   8'hFD,  16'hFFF1, "s5x-3");
        op8(1'b1, 8'd0,   8'hF9,  16'h0000, "s0x-7");
        op8(1'b0, 8'd200, 8'd1,   16'd200,  "u200x1");
        op8(1'b0, 8'd3,   8'd0,   16'd0,    "u3x0");
        op8(1'b0, 8'd7,   8'd128, 16'd896,  "u7x128");

        // start held high and operands toggled while busy
        signed8 = 1'b0; a8 = 8'd12; b8 = 8'd10; start8 = 1'b1;
        @(posedge clk); #1;
        nvalid = 0;
        got    = '0;
        for (int i = 0; i < 30; i++) begin
            if (valid8) begin
                nvalid++;
                got    = s8;
                start8 = 1'b0;
            end
            a8 = a8 + 8'd37;
            b8 = ~b8;
            @(posedge clk); #1;
        end
        start8 = 1'b0;
        check("held start valid count", 32'(nvalid), 32'd1);
        check("held start product",     32'(got),    32'h0078);

        // reset in the middle of a run
        signed8 = 1'b0; a8 = 8'hAA; b8 = 8'hFF; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("mid-run busy", 32'(busy8), 32'd1);
        rst_n = 1'b0;
        #1;
        check("async rst busy",  32'(busy8),  32'd0);
        check("async rst valid", 32'(valid8), 32'd0);
        check("async rst s",     32'(s8),     32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("post rst idle", 32'(busy8), 32'd0);
        op8(1'b0, 8'h13, 8'h11, 16'h0143, "after_rst");

        // exhaustive 4-bit sweep, back-to-back starts
        for (int s = 0; s < 2; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    sa = (s == 1 && a > 7) ? a - 16 : a;
                    sb = (s == 1 && b > 7) ? b - 16 : b;
                    op4(s[0], 4'(a), 4'(b), 8'(sa * sb));
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/multip_seq_nbits.md
Name: multip_seq_nbits

Overview:
Parametrised sequential shift-add multiplier. It is the iterative successor of the combinational array multiplier in the arithmetic datapath, trading latency for area. It adds signed/unsigned operation and a start/valid handshake. One partial product is accumulated per clock cycle.

Parameters:
NB_BITS, 8, operand width N; legal range 2..32; result width 2N.

Ports:
clk_i  in  1  rising-edge clock
rst_n_i  in  1  asynchronous active-low reset
start_i  in  1  request; sampled only when busy_o=0
signed_i  in  1  1 = two's-complement operands, 0 = unsigned; sampled with start_i
op1_i  in  N  multiplicand; sampled with start_i
op2_i  in  N  multiplier; sampled with start_i
busy_o  out  1  high from the cycle after accept until and including the valid_o cycle
valid_o  out  1  one-cycle pulse; s_o is valid
s_o  out  2N  product; held until the next valid_o

Behaviour:
- Reset: asynchronous, active-low; applies immediately at any point, including mid-operation, and discards the operation in flight. Values during reset: state=IDLE, busy_o=0, valid_o=0, s_o=0, all internal registers 0.
- IDLE: busy_o=0.
  - On start_i=1, latch operands and go to RUN.
  - If signed_i=1: load |op1_i| and |op2_i|, and latch neg = op1[N-1] XOR op2[N-1].
  - Else: load operands raw, neg=0.
  - Multiplicand register mcand is 2N wide, zero-extended. Multiplier register mplr is N wide. Accumulator acc (2N) cleared. Step counter cnt cleared.
- Magnitude of -2^(N-1) is 2^(N-1); it fits unsigned in N bits. No overflow is possible.
- RUN: one step per cycle.
  - If mplr[0]=1, acc <= acc + mcand, modulo 2^2N.
  - mcand <= mcand << 1; mplr <= mplr >> 1; cnt <= cnt + 1.
  - After step N (cnt = N-1 at the edge), go to FIN.
- FIN:
  - s_o <= neg ? (~acc + 1) : acc.
  - valid_o=1 for exactly one cycle; go to IDLE.
- Latency: start accepted at edge 0; valid_o high in cycle N+1 (fixed N+2 clock edges start-to-valid inclusive of FIN). busy_o is high for N+1 cycles.
- Back-to-back: start_i may be asserted in the cycle after valid_o and is accepted then. Maximum throughput is one result per N+2 cycles.
- start_i while busy_o=1 is ignored; no queuing, no error flag. Operand changes while busy have no effect.
- Result for a 0 operand in signed mode: neg may be 1, but ~0+1 = 0, so s_o=0. The sign fix must not produce -0 artefacts.
- s_o changes only on the FIN edge or on reset.

Optional Feature:
MULTIP_SEQ_EARLY_TERM_EN
- Defined: in RUN, if the next mplr value (after shift) is 0, go to FIN immediately. Latency = 2 + index of the highest set bit of the (magnitude) multiplier. For multiplier magnitude 0, the step count is 1, so valid_o comes in cycle 2. Results are identical to the non-terminated path. busy_o tracks the shortened sequence.
- Undefined: fixed latency as above. The early-exit comparator is not present.

Decomposition:
- Package multip_pkg:
  - state enum (IDLE, RUN, FIN), 2 bits.
  - Function for two's-complement magnitude of an N-bit value.
  - Constant MULTIP_NB_BITS_DEF=8.
- Sub-module adder_nbits (parameter NB_BITS = 2N): combinational accumulate adder acc + mcand, no carry-out used. Keeps the FSM/datapath module free of arithmetic.
- FSM and registers stay in multip_seq_nbits.

Test Plan:
1. NB_BITS=8, unsigned, op1=255, op2=255, start pulse -> valid_o exactly 9 cycles after accept cycle (non-ET), s_o=16'hFE01, busy_o high 9 cycles.
2. Signed: -128 x -128 -> s_o=16'h4000. -1 x 127 -> 16'hFF81. 5 x -3 -> 16'hFFF1. 0 x -7 -> 16'h0000.
3. Exhaustive NB_BITS=4, both modes, all 256 pairs, back-to-back starts on the cycle after each valid_o -> every s_o matches the reference model, no lost requests.
4. start_i held high and operands toggled during RUN -> only the first operands are used; exactly one valid_o per accepted request.
5. rst_n_i low for one cycle mid-RUN (after step 3) -> outputs immediately 0, IDLE. The next start yields a correct product with full latency.
6. MULTIP_SEQ_EARLY_TERM_EN defined, NB_BITS=8:
   - 200 x 1 -> valid_o 2 cycles after accept, s_o=200.
   - 3 x 0 -> s_o=0 at 2 cycles.
   - 7 x 128 -> s_o=896 at 9 cycles.
